spi_slave_rx: RTL and testbench

Downstream receive stage for the 4-bit SPI master. It sits on the same system clock, samples the master's `ss`/`mosi` lines and deserialises one word per frame, MSB first. It presents each completed word to the local consumer through a valid/ready handshake, with a one-word holding register. Short frames and overruns are flagged to the consumer.

---
 rtl/spi_slave_rx.sv | 54 +++++
 tb/tb_spi_slave_rx.sv | 129 ++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: samples ss/mosi on the system clock, deserialises MSB-first words into a one-word valid/ready holding register.
module spi_slave_rx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss,
  input  logic             mosi,
  input  logic             rx_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             short_err,
  output logic             overrun,
  output logic             busy
);
  typedef enum logic {WAIT, SHIFT} state_t;
  state_t state, state_n;
  logic ss_q;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic frame_end, full, good, load;
  always_comb begin
    frame_end = state == SHIFT && !ss_q && ss;
    full = bit_cnt >= CNT_W'(WIDTH);
    good = frame_end && full;
    load = good && (!rx_valid || rx_ready);
    state_n = state == WAIT ? (ss ? WAIT : SHIFT) : (frame_end ? WAIT : SHIFT);
    bit_cnt_n = frame_end ? '0 : ss ? bit_cnt : state == WAIT ? CNT_W'(1) : full ? bit_cnt : bit_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT;
      ss_q <= 1'b1;
      shreg <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      short_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      ss_q <= ss;
      bit_cnt <= bit_cnt_n;
      if (!ss) shreg <= {shreg[WIDTH-2:0], mosi};
      if (load) rx_data <= shreg;
      rx_valid <= load || (rx_valid && !rx_ready);
      short_err <= frame_end && !full;
      overrun <= (good && rx_valid && !rx_ready) || (overrun && !ovr_clr);
    end
  end
  assign busy = state == SHIFT;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed frames with a word scoreboard popped on each accepted handshake.
module tb_spi_slave_rx;
  logic clk = 1'b0, rst, ss, mosi, rx_ready, ovr_clr;
  logic [3:0] rx_data;
  logic rx_valid, short_err, overrun, busy;
  int checks = 0, errors = 0, pops = 0, n_short = 0;
  logic [3:0] sb[$];
  logic [3:0] exp_w;
  spi_slave_rx dut (
    .clk(clk), .rst(rst), .ss(ss), .mosi(mosi), .rx_ready(rx_ready), .ovr_clr(ovr_clr),
    .rx_data(rx_data), .rx_valid(rx_valid), .short_err(short_err), .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] w);
    ss = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      mosi = w[i];
      tick();
    end
    ss = 1'b1;
  endtask
  always @(negedge clk) begin
    if (short_err) n_short++;
    if (!rst && rx_valid && rx_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        exp_w = sb.pop_front();
        pops++;
        chk("rx_word", 32'(rx_data), 32'(exp_w));
      end
    end
  end
  initial begin
    rst = 1'b1; ss = 1'b1; mosi = 1'b0; rx_ready = 1'b0; ovr_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_short_err", 32'(short_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    sb.push_back(4'hD);
    send(4'hD);
    chk("t1_busy_shift", 32'(busy), 1);
    chk("t1_valid_early", 32'(rx_valid), 0);
    tick();
    chk("t1_valid", 32'(rx_valid), 1);
    chk("t1_data", 32'(rx_data), 32'hD);
    chk("t1_short", 32'(short_err), 0);
    chk("t1_busy_idle", 32'(busy), 0);
    rx_ready = 1'b1;
    tick();
    chk("t1_consumed", 32'(rx_valid), 0);
    sb.push_back(4'hD);
    send(4'hD);
    tick();
    chk("t2_valid_a", 32'(rx_valid), 1);
    chk("t2_data_a", 32'(rx_data), 32'hD);
    sb.push_back(4'h6);
    send(4'h6);
    tick();
    chk("t2_valid_b", 32'(rx_valid), 1);
    chk("t2_data_b", 32'(rx_data), 32'h6);
    tick();
    chk("t2_pulse_end", 32'(rx_valid), 0);
    chk("t2_overrun", 32'(overrun), 0);
    ss = 1'b0; mosi = 1'b1; tick();
    mosi = 1'b0; tick();
    ss = 1'b1; tick();
    chk("t3_short", 32'(short_err), 1);
    chk("t3_valid", 32'(rx_valid), 0);
    tick();
    chk("t3_short_1cyc", 32'(short_err), 0);
    rx_ready = 1'b0;
    sb.push_back(4'hA);
    send(4'hA);
    tick();
    send(4'h3);
    tick();
    chk("t4_overrun", 32'(overrun), 1);
    chk("t4_data_held", 32'(rx_data), 32'hA);
    chk("t4_valid", 32'(rx_valid), 1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    chk("t4_ovr_clr", 32'(overrun), 0);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    chk("t4_accepted", 32'(rx_valid), 0);
    ss = 1'b0; mosi = 1'b1; tick();
    mosi = 1'b0; tick();
    mosi = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_data", 32'(rx_data), 0);
    ss = 1'b1; tick();
    chk("t5_no_short_a", 32'(short_err), 0);
    tick();
    chk("t5_no_short_b", 32'(short_err), 0);
    sb.push_back(4'h9);
    send(4'h9);
    tick();
    chk("t5_valid", 32'(rx_valid), 1);
    chk("t5_data", 32'(rx_data), 32'h9);
    sb.push_back(4'h5);
    send(4'h5);
    rx_ready = 1'b1;
    tick();
    chk("t6_valid", 32'(rx_valid), 1);
    chk("t6_data", 32'(rx_data), 32'h5);
    chk("t6_overrun", 32'(overrun), 0);
    tick();
    chk("t6_drained", 32'(rx_valid), 0);
    rx_ready = 1'b0;
    tick();
    chk("sb_empty", 32'(sb.size()), 0);
    chk("pops", 32'(pops), 6);
    chk("short_count", 32'(n_short), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
